// File: rtl/npc_pkg.sv
// Shared NPC core definitions used by the write-back unit.
//   XLEN : data width
//   NREG : number of architectural registers (RV32E = 16)
//   AW   : register address width of the register file ports
package npc_pkg;
  localparam int XLEN = 32;
  localparam int NREG = 16;
  localparam int AW   = 5;
  localparam int IW   = $clog2(NREG);  // bits needed to index the busy map

  typedef logic [AW-1:0]   reg_addr_t;
  typedef logic [XLEN-1:0] word_t;

  // A register that can hold a pending write: 1..NREG-1 (x0 is hardwired).
  function automatic logic rd_legal(reg_addr_t a);
    return (a != '0) && (int'(a) < NREG);
  endfunction

  // Index outside the architectural register file.
  function automatic logic rd_illegal(reg_addr_t a);
    return int'(a) >= NREG;
  endfunction
endpackage

// File: rtl/npc_wbu_scoreboard.sv
// Per-register busy bitmap for RAW/WAW hazard detection.
//   clk, rst               : clock, async active-low reset
//   rs1/rs2_addr_i -> _o   : combinational busy queries (x0 / illegal read 0)
//   iss_valid_i, iss_rd_i  : issue request; iss_ready_o = !busy[iss_rd_i]
//   clr_en_i, clr_addr_i   : clear request, driven by the write-back register
//   busy_o                 : full bitmap, used for the write-back error check
module npc_wbu_scoreboard
  import npc_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic [AW-1:0]   rs1_addr_i,
  input  logic [AW-1:0]   rs2_addr_i,
  output logic            rs1_busy_o,
  output logic            rs2_busy_o,
  input  logic            iss_valid_i,
  input  logic [AW-1:0]   iss_rd_i,
  output logic            iss_ready_o,
  input  logic            clr_en_i,
  input  logic [AW-1:0]   clr_addr_i,
  output logic [NREG-1:0] busy_o
);
  logic [NREG-1:0] busy_q, busy_d;
  logic            set_en, clr_en;

  function automatic logic lookup(logic [NREG-1:0] map, reg_addr_t a);
    return rd_legal(a) ? map[a[IW-1:0]] : 1'b0;
  endfunction

  assign rs1_busy_o  = lookup(busy_q, rs1_addr_i);
  assign rs2_busy_o  = lookup(busy_q, rs2_addr_i);
  // Uses the registered map only, so a clear landing this edge cannot
  // open the issue gate early.
  assign iss_ready_o = !lookup(busy_q, iss_rd_i);
  assign busy_o      = busy_q;

  assign set_en = iss_valid_i && iss_ready_o && rd_legal(iss_rd_i);
  assign clr_en = clr_en_i && rd_legal(clr_addr_i);

  // Set wins over clear on the same index.
  always_comb begin
    busy_d = busy_q;
    if (clr_en) busy_d[clr_addr_i[IW-1:0]] = 1'b0;
    if (set_en) busy_d[iss_rd_i[IW-1:0]]   = 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) busy_q <= '0;
    else      busy_q <= busy_d;
  end
endmodule

// File: rtl/npc_wbu.sv
// NPC write-back unit: arbitrates ALU and LSU results (LSU has fixed
// priority), registers one result per cycle onto the register-file write
// port and tracks pending writes in a busy scoreboard.
//   clk, rst                       : clock, async active-low reset
//   iss_valid/iss_rd/iss_ready     : IDU issue handshake (WAW stall)
//   rs1/rs2_addr -> rs1/rs2_busy   : IDU RAW hazard queries
//   alu_valid/rd/data/ready        : ALU result channel
//   lsu_valid/rd/data/ready        : LSU load-return channel (always ready)
//   rd_addr/rd_data/rd_wen         : register-file write port (latency 1)
//   commit_cnt                     : retired-result counter (wraps)
//   wb_err                         : sticky protocol-error flag
module npc_wbu
  import npc_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            iss_valid,
  input  logic [AW-1:0]   iss_rd,
  output logic            iss_ready,
  input  logic [AW-1:0]   rs1_addr,
  input  logic [AW-1:0]   rs2_addr,
  output logic            rs1_busy,
  output logic            rs2_busy,
  input  logic            alu_valid,
  input  logic [AW-1:0]   alu_rd,
  input  logic [XLEN-1:0] alu_data,
  output logic            alu_ready,
  input  logic            lsu_valid,
  input  logic [AW-1:0]   lsu_rd,
  input  logic [XLEN-1:0] lsu_data,
  output logic            lsu_ready,
  output logic [AW-1:0]   rd_addr,
  output logic [XLEN-1:0] rd_data,
  output logic            rd_wen,
  output logic [31:0]     commit_cnt,
  output logic            wb_err
);
  logic [NREG-1:0] busy;
  reg_addr_t       rd_addr_q, sel_rd;
  word_t           rd_data_q, sel_data;
  logic            rd_wen_q, acc, sel_busy, err_d, err_q;
  logic [31:0]     cnt_q;

  npc_wbu_scoreboard u_sb (
    .clk         (clk),
    .rst         (rst),
    .rs1_addr_i  (rs1_addr),
    .rs2_addr_i  (rs2_addr),
    .rs1_busy_o  (rs1_busy),
    .rs2_busy_o  (rs2_busy),
    .iss_valid_i (iss_valid),
    .iss_rd_i    (iss_rd),
    .iss_ready_o (iss_ready),
    .clr_en_i    (rd_wen_q),
    .clr_addr_i  (rd_addr_q),
    .busy_o      (busy)
  );

  // LSU cannot be stalled; ALU waits whenever a load returns.
  assign lsu_ready = 1'b1;
  assign alu_ready = !lsu_valid;
  assign acc       = lsu_valid || alu_valid;
  assign sel_rd    = lsu_valid ? lsu_rd   : alu_rd;
  assign sel_data  = lsu_valid ? lsu_data : alu_data;
  assign sel_busy  = rd_legal(sel_rd) ? busy[sel_rd[IW-1:0]] : 1'b0;

  always_comb begin
    err_d = err_q;
    if (acc && rd_legal(sel_rd) && !sel_busy)            err_d = 1'b1;
    if (acc && rd_illegal(sel_rd))                       err_d = 1'b1;
    if (iss_valid && iss_ready && rd_illegal(iss_rd))    err_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_addr_q <= '0;
      rd_data_q <= '0;
      rd_wen_q  <= 1'b0;
      cnt_q     <= '0;
      err_q     <= 1'b0;
    end else begin
      rd_wen_q <= acc && rd_legal(sel_rd);
      if (acc) begin
        rd_addr_q <= sel_rd;
        rd_data_q <= sel_data;
        cnt_q     <= cnt_q + 32'd1;
      end
      err_q <= err_d;
    end
  end

  assign rd_addr    = rd_addr_q;
  assign rd_data    = rd_data_q;
  assign rd_wen     = rd_wen_q;
  assign commit_cnt = cnt_q;
  assign wb_err     = err_q;
endmodule

// File: tb/tb_npc_wbu.sv
// Directed bench for npc_wbu. Stimulus pushes each expected register-file
// write into exp_q; an independent negedge monitor pops and compares every
// rd_wen pulse, flagging writes nobody expected.
module tb_npc_wbu;
  logic        clk = 1'b0, rst = 1'b0;
  logic        iss_valid = 1'b0, iss_ready;
  logic [4:0]  iss_rd = '0, rs1_addr = '0, rs2_addr = '0;
  logic        rs1_busy, rs2_busy;
  logic        alu_valid = 1'b0, alu_ready;
  logic [4:0]  alu_rd = '0;
  logic [31:0] alu_data = '0;
  logic        lsu_valid = 1'b0, lsu_ready;
  logic [4:0]  lsu_rd = '0;
  logic [31:0] lsu_data = '0;
  logic [4:0]  rd_addr;
  logic [31:0] rd_data, commit_cnt;
  logic        rd_wen, wb_err;

  typedef struct { logic [4:0] a; logic [31:0] d; } wr_t;
  wr_t exp_q[$];
  int  n_chk = 0, n_fail = 0;
  logic [31:0] cnt_exp = 0;

  always #5 clk = ~clk;

  npc_wbu dut (
    .clk(clk), .rst(rst),
    .iss_valid(iss_valid), .iss_rd(iss_rd), .iss_ready(iss_ready),
    .rs1_addr(rs1_addr), .rs2_addr(rs2_addr), .rs1_busy(rs1_busy), .rs2_busy(rs2_busy),
    .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data), .alu_ready(alu_ready),
    .lsu_valid(lsu_valid), .lsu_rd(lsu_rd), .lsu_data(lsu_data), .lsu_ready(lsu_ready),
    .rd_addr(rd_addr), .rd_data(rd_data), .rd_wen(rd_wen),
    .commit_cnt(commit_cnt), .wb_err(wb_err)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Accept at the coming edge: record expected write and commit.
  task automatic expect_wr(input logic [4:0] a, input logic [31:0] d);
    wr_t e;
    e.a = a; e.d = d;
    if (a != 0 && a < 16) exp_q.push_back(e);
    cnt_exp = cnt_exp + 1;
  endtask

  task automatic issue(input logic [4:0] r);
    iss_valid = 1'b1; iss_rd = r;
    #1 chk("iss_ready_free", {31'b0, iss_ready}, 32'd1);
    step();
    iss_valid = 1'b0;
  endtask

  task automatic alu_one(input logic [4:0] r, input logic [31:0] d);
    alu_valid = 1'b1; alu_rd = r; alu_data = d;
    expect_wr(r, d);
    step();
    alu_valid = 1'b0;
  endtask

  // Monitor: every write must match the oldest expected one.
  always @(negedge clk) begin
    if (rst && rd_wen) begin
      if (exp_q.size() == 0) begin
        n_chk++; n_fail++;
        $display("FAIL unexpected_write: got x%0d=%h expected no write", rd_addr, rd_data);
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        chk("wb_addr", {27'b0, rd_addr}, {27'b0, e.a});
        chk("wb_data", rd_data, e.d);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset then idle
    step(); step();
    rst = 1'b1;
    step();
    chk("rst_wen", {31'b0, rd_wen}, 0);
    chk("rst_cnt", commit_cnt, 0);
    chk("rst_err", {31'b0, wb_err}, 0);
    begin
      int nb = 0;
      for (int a = 0; a < 32; a++) begin
        rs1_addr = 5'(a); rs2_addr = 5'(31 - a);
        #0.1;
        nb += rs1_busy + rs2_busy;
      end
      chk("rst_busy_all", nb, 0);
    end
    rs1_addr = 0; rs2_addr = 0;

    // Issue / writeback x5
    issue(5);
    rs1_addr = 5;
    #1 chk("rs1_busy_x5", {31'b0, rs1_busy}, 1);
    alu_valid = 1'b1; alu_rd = 5; alu_data = 32'hDEADBEEF;
    #1 chk("alu_ready_idle", {31'b0, alu_ready}, 1);
    expect_wr(5, 32'hDEADBEEF);
    step();
    alu_valid = 1'b0;
    chk("x5_busy_wb_cycle", {31'b0, rs1_busy}, 1);
    chk("cnt_1", commit_cnt, 1);
    step();
    chk("x5_busy_cleared", {31'b0, rs1_busy}, 0);

    // Collision: LSU x3 and ALU x7 together
    issue(3); issue(7);
    rs1_addr = 3; rs2_addr = 7;
    #1 chk("busy_x3", {31'b0, rs1_busy}, 1);
    chk("busy_x7", {31'b0, rs2_busy}, 1);
    lsu_valid = 1'b1; lsu_rd = 3; lsu_data = 32'h11;
    alu_valid = 1'b1; alu_rd = 7; alu_data = 32'h22;
    #1 chk("alu_ready_collide", {31'b0, alu_ready}, 0);
    chk("lsu_ready", {31'b0, lsu_ready}, 1);
    expect_wr(3, 32'h11);
    step();
    lsu_valid = 1'b0;
    #1 chk("alu_ready_after", {31'b0, alu_ready}, 1);
    expect_wr(7, 32'h22);
    step();
    alu_valid = 1'b0;
    step(); step();
    chk("collide_clear", {30'b0, rs1_busy, rs2_busy}, 0);
    chk("cnt_3", commit_cnt, cnt_exp);
    chk("err_clean", {31'b0, wb_err}, 0);

    // WAW stall on x4
    issue(4);
    iss_valid = 1'b1; iss_rd = 4;
    #1 chk("waw_stall0", {31'b0, iss_ready}, 0);
    step();
    chk("waw_stall1", {31'b0, iss_ready}, 0);
    alu_valid = 1'b1; alu_rd = 4; alu_data = 32'h44;
    expect_wr(4, 32'h44);
    step();
    alu_valid = 1'b0;
    chk("waw_stall_wen_cycle", {31'b0, iss_ready}, 0);
    step();
    chk("waw_release", {31'b0, iss_ready}, 1);
    step();                     // re-issue of x4 accepted here
    iss_valid = 1'b0;
    rs1_addr = 4;
    #1 chk("x4_rebusy", {31'b0, rs1_busy}, 1);
    alu_one(4, 32'h4444);
    step();

    // Boundary queries: x15 legal, x16 illegal
    issue(15);
    rs1_addr = 15; rs2_addr = 16;
    #1 chk("busy_x15", {31'b0, rs1_busy}, 1);
    chk("busy_x16", {31'b0, rs2_busy}, 0);
    alu_one(15, 32'hF00D);
    step();
    chk("err_still_clean", {31'b0, wb_err}, 0);

    // rd=0, then unissued x9
    alu_one(0, 32'h55);
    chk("cnt_rd0", commit_cnt, cnt_exp);
    step();
    chk("rd0_no_wen", {31'b0, rd_wen}, 0);
    chk("err_rd0", {31'b0, wb_err}, 0);
    alu_one(9, 32'h99);
    chk("err_x9", {31'b0, wb_err}, 1);
    step(); step();
    chk("err_sticky", {31'b0, wb_err}, 1);
    chk("cnt_x9", commit_cnt, cnt_exp);

    // Async reset mid-flight
    issue(2);
    lsu_valid = 1'b1; lsu_rd = 2; lsu_data = 32'h77;
    step();                     // accepted; write pending in this cycle
    lsu_valid = 1'b0;
    chk("pre_rst_wen", {31'b0, rd_wen}, 1);
    rst = 1'b0;
    rs1_addr = 2;
    #1 chk("arst_wen", {31'b0, rd_wen}, 0);
    chk("arst_busy_x2", {31'b0, rs1_busy}, 0);
    chk("arst_cnt", commit_cnt, 0);
    chk("arst_err", {31'b0, wb_err}, 0);
    cnt_exp = 0;
    step();
    rst = 1'b1;
    step(); step(); step();
    chk("post_rst_wen", {31'b0, rd_wen}, 0);

    // Illegal issue sets error, no busy bit
    iss_valid = 1'b1; iss_rd = 20; rs1_addr = 20;
    #1 chk("iss_illegal_ready", {31'b0, iss_ready}, 1);
    step();
    iss_valid = 1'b0;
    chk("err_illegal_iss", {31'b0, wb_err}, 1);
    chk("illegal_no_busy", {31'b0, rs1_busy}, 0);
    step(); step();

    chk("exp_q_drained", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
